// File: rtl/pe_input_fifo.sv
// Circular FIFO for one PE input stream: registered one-cycle reads, full/empty/almost-full flags and occupancy.
// Optional sticky overflow/underflow outputs are enabled by defining PE_FIFO_ERR_FLAGS_EN.
module pe_input_fifo #(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      wen,
  input  logic [DATA_WIDTH-1:0]     din,
  input  logic                      ren,
  output logic [DATA_WIDTH-1:0]     dout,
  output logic                      dout_valid,
  output logic                      full,
  output logic                      empty,
  output logic                      almost_full,
  output logic [$clog2(DEPTH):0]    count
`ifdef PE_FIFO_ERR_FLAGS_EN
  ,
  output logic                      overflow,
  output logic                      underflow
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);
  localparam logic [AW:0] AF_LVL  = (AW+1)'(DEPTH - 1);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]           r_wptr;
  logic [AW:0]           r_rptr;
  logic [DATA_WIDTH-1:0] r_dout;
  logic                  r_dout_valid;

  logic                  w_full;
  logic                  w_empty;
  logic [AW:0]           w_count;
  logic                  w_wr_acc;
  logic                  w_rd_acc;

  // Flags derive only from the pointer registers, so requests never feed them combinationally.
  assign w_full   = (r_wptr[AW-1:0] == r_rptr[AW-1:0]) && (r_wptr[AW] != r_rptr[AW]);
  assign w_empty  = (r_wptr == r_rptr);
  assign w_count  = r_wptr - r_rptr;
  assign w_wr_acc = wen && !w_full;
  assign w_rd_acc = ren && !w_empty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_wr_acc) r_wptr <= r_wptr + PTR_ONE;
      if (w_rd_acc) r_rptr <= r_rptr + PTR_ONE;
    end
  end

  // Storage is deliberately left unreset; the pointers alone define which entries are live.
  always_ff @(posedge clk) begin
    if (w_wr_acc) r_mem[r_wptr[AW-1:0]] <= din;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_dout       <= '0;
      r_dout_valid <= 1'b0;
    end else begin
      r_dout_valid <= w_rd_acc;
      if (w_rd_acc) r_dout <= r_mem[r_rptr[AW-1:0]];
    end
  end

`ifdef PE_FIFO_ERR_FLAGS_EN
  logic r_overflow;
  logic r_underflow;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (wen && w_full)  r_overflow  <= 1'b1;
      if (ren && w_empty) r_underflow <= 1'b1;
    end
  end

  assign overflow  = r_overflow;
  assign underflow = r_underflow;
`endif

  assign dout        = r_dout;
  assign dout_valid  = r_dout_valid;
  assign full        = w_full;
  assign empty       = w_empty;
  assign almost_full = (w_count >= AF_LVL);
  assign count       = w_count;

endmodule

// File: tb/tb_pe_input_fifo.sv
// Self-checking bench for pe_input_fifo: directed and randomized traffic compared against a queue-based model.
module tb_pe_input_fifo;
  localparam int DW    = 16;
  localparam int DEPTH = 8;
  localparam int AW    = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          wen;
  logic          ren;
  logic [DW-1:0] din;
  logic [DW-1:0] dout;
  logic          dout_valid;
  logic          full;
  logic          empty;
  logic          almost_full;
  logic [AW:0]   count;
`ifdef PE_FIFO_ERR_FLAGS_EN
  logic          overflow;
  logic          underflow;
`endif

  always #5 clk = ~clk;

  pe_input_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk         (clk),
    .rst         (rst),
    .wen         (wen),
    .din         (din),
    .ren         (ren),
    .dout        (dout),
    .dout_valid  (dout_valid),
    .full        (full),
    .empty       (empty),
    .almost_full (almost_full),
    .count       (count)
`ifdef PE_FIFO_ERR_FLAGS_EN
    ,
    .overflow    (overflow),
    .underflow   (underflow)
`endif
  );

  // Reference model: a plain queue of stored words plus the expected registered outputs.
  logic [DW-1:0] q[$];
  logic [DW-1:0] exp_dout;
  logic          exp_dv;
  logic          exp_ovf;
  logic          exp_unf;
  int            n_total = 0;
  int            n_pass  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  task automatic model_reset();
    q.delete();
    exp_dout = '0;
    exp_dv   = 1'b0;
    exp_ovf  = 1'b0;
    exp_unf  = 1'b0;
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".count"},       32'(count),       32'(q.size()));
    chk({tag, ".full"},        32'(full),        32'(q.size() == DEPTH));
    chk({tag, ".empty"},       32'(empty),       32'(q.size() == 0));
    chk({tag, ".almost_full"}, 32'(almost_full), 32'(q.size() >= DEPTH - 1));
    chk({tag, ".dout_valid"},  32'(dout_valid),  32'(exp_dv));
    chk({tag, ".dout"},        32'(dout),        32'(exp_dout));
`ifdef PE_FIFO_ERR_FLAGS_EN
    chk({tag, ".overflow"},    32'(overflow),    32'(exp_ovf));
    chk({tag, ".underflow"},   32'(underflow),   32'(exp_unf));
`endif
  endtask

  // Drive one cycle of requests, predict acceptance from the pre-edge occupancy, then check after the edge.
  task automatic cycle(input logic w, input logic [DW-1:0] d, input logic r, input string tag);
    logic wa, ra;
    int   n;
    wen = w;
    din = d;
    ren = r;
    n  = q.size();
    wa = w && (n < DEPTH);
    ra = r && (n > 0);
    if (w && n == DEPTH) exp_ovf = 1'b1;
    if (r && n == 0)     exp_unf = 1'b1;
    @(posedge clk);
    #1;
    exp_dv = ra;
    if (ra) exp_dout = q.pop_front();
    if (wa) q.push_back(d);
    check_all(tag);
  endtask

  initial begin
    rst = 1'b1;
    wen = 1'b0;
    ren = 1'b0;
    din = '0;
    model_reset();
    #3;
    check_all("async_rst");
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;

    for (int i = 0; i < 10; i++) cycle(1'b0, '0, 1'b0, "idle");

    for (int i = 1; i <= 8; i++) cycle(1'b1, DW'(i), 1'b0, "fill");
    cycle(1'b1, 16'hFFFF, 1'b0, "wr_full");
    for (int i = 0; i < 8; i++) cycle(1'b0, '0, 1'b1, "drain");
    cycle(1'b0, '0, 1'b0, "drain_idle");

    for (int i = 0; i < 3; i++) cycle(1'b1, DW'(16'h00F0 + i), 1'b0, "wrap_pre");
    for (int i = 0; i < 20; i++) cycle(1'b1, DW'(16'h0100 + i), 1'b1, "wrap");
    for (int i = 0; i < 3; i++) cycle(1'b0, '0, 1'b1, "wrap_drain");

    for (int i = 0; i < 8; i++) cycle(1'b1, DW'(16'h0200 + i), 1'b0, "bnd_fill");
    cycle(1'b1, 16'hBEEF, 1'b1, "full_wr_rd");
    for (int i = 0; i < 7; i++) cycle(1'b0, '0, 1'b1, "bnd_drain");
    cycle(1'b1, 16'h00AA, 1'b1, "empty_wr_rd");
    cycle(1'b0, '0, 1'b1, "rd_aa");

    for (int i = 0; i < 5; i++) cycle(1'b1, DW'(16'h0300 + i), 1'b0, "pre_rst");
    wen = 1'b0;
    ren = 1'b0;
    rst = 1'b1;
    #2;
    model_reset();
    check_all("mid_rst");
    rst = 1'b0;
    cycle(1'b0, '0, 1'b1, "rd_after_rst");

    for (int i = 0; i < 400; i++) begin
      logic w, r;
      if ((i / 50) % 2 == 0) begin
        w = ($urandom_range(0, 3) != 0);
        r = ($urandom_range(0, 3) == 0);
      end else begin
        w = ($urandom_range(0, 3) == 0);
        r = ($urandom_range(0, 3) != 0);
      end
      cycle(w, DW'($urandom), r, "rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
